// File: rtl/spectrum_pkg.sv
// Shared types for the spectrum-clock screen RAM arbiter.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package spectrum_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;

    // Who issued the RAM access whose read data returns this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    // CPU request handshake state
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_PEND = 2'd1,
        C_BUSY = 2'd2,
        C_DONE = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port 8K x 8 screen RAM between Z80 (cpu_*) and display fetch (vid_*).
// Latency: grant cycle N drives the RAM; cpu_ack / vid_valid and read data appear in N+1.
// Backpressure: video wins unless it has taken MAX_VID_STREAK grants while the CPU waits; CPU stalls via cpu_wait_n.
// Ports: clk/reset; CPU req/we/addr/wdata -> rdata/ack/wait_n; video req/addr -> gnt/rdata/valid;
//        RAM ce/we/addr/wdata -> rdata (registered read, data one cycle after ce).
module vram_arbiter
    import spectrum_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = (MAX_VID_STREAK < 2) ? 1 : $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

    cpu_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    owner_e              own_q, own_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   vid_rdata_q;

    logic cpu_pending;
    logic cpu_grant;

    // Arbitration and RAM drive. Reset gates every grant so a request
    // present during reset never reaches the RAM.
    always_comb begin
        // Requiring cpu_req here makes a dropped request in C_PEND fall
        // back to idle without touching the RAM.
        cpu_pending = ~reset & cpu_req & ((state_q == C_IDLE) | (state_q == C_PEND));
        cpu_grant   = cpu_pending & (~vid_req | (streak_q == STREAK_MAX));
        vid_gnt     = ~reset & vid_req & ~cpu_grant;

        mem_ce    = cpu_grant | vid_gnt;
        mem_we    = cpu_grant & cpu_we;
        mem_addr  = cpu_grant ? cpu_addr : vid_addr;
        mem_wdata = cpu_wdata;

        cpu_wait_n = ~(cpu_pending | (~reset & (state_q == C_BUSY)));

        cpu_ack   = ~reset & (own_q == OWN_CPU);
        vid_valid = ~reset & (own_q == OWN_VID);

        // Read data bypasses the hold register in the return cycle so it
        // lines up with ack/valid; otherwise the last value is held.
        if (reset) begin
            cpu_rdata = '0;
            vid_rdata = '0;
        end else begin
            cpu_rdata = (cpu_ack & rd_q) ? mem_rdata : cpu_rdata_q;
            vid_rdata = vid_valid ? mem_rdata : vid_rdata_q;
        end
    end

    // CPU FSM, streak counter and owner pipe next state
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        own_d    = OWN_NONE;
        rd_d     = 1'b0;

        case (state_q)
            C_IDLE: begin
                if (cpu_grant)    state_d = C_BUSY;
                else if (cpu_req) state_d = C_PEND;
            end
            C_PEND: begin
                if (cpu_grant)     state_d = C_BUSY;
                else if (!cpu_req) state_d = C_IDLE;
            end
            C_BUSY:  state_d = C_DONE;
            // Hold here until the Z80 releases rd/wr so one bus cycle
            // yields exactly one RAM access.
            C_DONE: begin
                if (!cpu_req) state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase

        if (!cpu_pending || cpu_grant) begin
            streak_d = '0;
        end else if (vid_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end

        if (cpu_grant) begin
            own_d = OWN_CPU;
            rd_d  = ~cpu_we;
        end else if (vid_gnt) begin
            own_d = OWN_VID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= C_IDLE;
            streak_q    <= '0;
            own_q       <= OWN_NONE;
            rd_q        <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            own_q       <= own_d;
            rd_q        <= rd_d;
            cpu_rdata_q <= cpu_rdata;
            vid_rdata_q <= vid_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural screen RAM.
// Expected read bytes go into queues at issue time; a negedge monitor pops them on cpu_ack / vid_valid.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ack, cpu_wait_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic [DW-1:0] vid_rdata;
    logic          vid_valid;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] cpu_exp_d[$];
    logic          cpu_exp_rd[$];
    logic [DW-1:0] vid_exp_d[$];
    logic [DW-1:0] last_cpu_rd = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VID_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_valid(vid_valid),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port RAM, registered read
    always @(posedge clk) begin
        if (mem_ce && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_ce && !mem_we) mem_rdata <= ram[mem_addr];
    end

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 8'((a * 7) + 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (cpu_ack) begin
                if (cpu_exp_d.size() == 0) begin
                    chk("cpu_ack_unexpected", 1, 0);
                end else begin
                    logic          r;
                    logic [DW-1:0] d;
                    r = cpu_exp_rd.pop_front();
                    d = cpu_exp_d.pop_front();
                    if (r) begin
                        chk("cpu_rdata", 32'(cpu_rdata), 32'(d));
                        last_cpu_rd = d;
                    end else begin
                        chk("cpu_rdata_held_on_write", 32'(cpu_rdata), 32'(last_cpu_rd));
                    end
                end
            end
            if (vid_valid) begin
                if (vid_exp_d.size() == 0) chk("vid_valid_unexpected", 1, 0);
                else chk("vid_rdata", 32'(vid_rdata), 32'(vid_exp_d.pop_front()));
            end
        end
    end

    // CPU access with request held for `hold` cycles, no video traffic
    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input int hold);
        int ce_n, we_n, ack_n;
        ce_n = 0; we_n = 0; ack_n = 0;
        cpu_exp_rd.push_back(!we);
        cpu_exp_d.push_back(exp_rd);
        for (int i = 0; i < hold; i++) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
            mid();
            if (mem_ce) ce_n++;
            if (mem_ce && mem_we) we_n++;
            if (cpu_ack) ack_n++;
            cyc();
        end
        cpu_req = 1'b0;
        mid();
        cyc();
        chk("cpu_op_ce_count", 32'(ce_n), 1);
        chk("cpu_op_we_count", 32'(we_n), 32'(we));
        chk("cpu_op_ack_count", 32'(ack_n), 1);
    endtask

    // Continuous video fetch from `base`, CPU read of 0x1800 raised at cycle cs.
    // The CPU must get the slot after four video grants: grant cs+4, ack cs+5.
    task automatic starve(input logic [AW-1:0] base, input int cs);
        logic [AW-1:0] vk;
        logic          eg;
        vk = '0;
        for (int c = 0; c < cs + 8; c++) begin
            vid_req  = 1'b1;
            vid_addr = base + vk;
            cpu_req  = (c >= cs) && (c <= cs + 5);
            cpu_we   = 1'b0;
            cpu_addr = 13'h1800;
            if (c == cs) begin
                cpu_exp_rd.push_back(1'b1);
                cpu_exp_d.push_back(8'h5A);
            end
            eg = (c != cs + 4);
            if (eg) vid_exp_d.push_back(pat(base + vk));
            mid();
            chk($sformatf("starve_vid_gnt_c%0d", c), 32'(vid_gnt), 32'(eg));
            chk($sformatf("starve_mem_addr_c%0d", c), 32'(mem_addr),
                eg ? 32'(base + vk) : 32'h1800);
            chk($sformatf("starve_ack_c%0d", c), 32'(cpu_ack), 32'(c == cs + 5));
            chk($sformatf("starve_wait_n_c%0d", c), 32'(cpu_wait_n),
                32'(!((c >= cs) && (c <= cs + 5))));
            if (eg) vk = vk + 1'b1;
            cyc();
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        mid();
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) ram[a] = pat(AW'(a));
        ram[13'h1800] = 8'h5A;

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        cyc(); cyc();

        // Reset state, with requests present to show grants are suppressed
        cpu_req = 1'b1; vid_req = 1'b1; cpu_addr = 13'h1800;
        mid();
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_vid_valid", 32'(vid_valid), 0);
        chk("rst_wait_n", 32'(cpu_wait_n), 1);
        chk("rst_vid_gnt", 32'(vid_gnt), 0);
        chk("rst_mem_ce", 32'(mem_ce), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_vid_rdata", 32'(vid_rdata), 0);
        cyc();
        cpu_req = 1'b0; vid_req = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        // CPU read alone, exact timing
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1800;
        cpu_exp_rd.push_back(1'b1); cpu_exp_d.push_back(8'h5A);
        mid();
        chk("rd_c0_mem_ce", 32'(mem_ce), 1);
        chk("rd_c0_mem_we", 32'(mem_we), 0);
        chk("rd_c0_mem_addr", 32'(mem_addr), 32'h1800);
        chk("rd_c0_wait_n", 32'(cpu_wait_n), 0);
        chk("rd_c0_ack", 32'(cpu_ack), 0);
        cyc();
        mid();
        chk("rd_c1_ack", 32'(cpu_ack), 1);
        chk("rd_c1_wait_n", 32'(cpu_wait_n), 0);
        chk("rd_c1_mem_ce", 32'(mem_ce), 0);
        cyc();
        cpu_req = 1'b0;
        mid();
        chk("rd_c2_wait_n", 32'(cpu_wait_n), 1);
        chk("rd_c2_rdata_held", 32'(cpu_rdata), 32'h5A);
        cyc();

        // CPU write held four cycles, then read it back
        cpu_op(1'b1, 13'h0010, 8'hC3, 8'h00, 4);
        cpu_op(1'b0, 13'h0010, 8'h00, 8'hC3, 2);

        // Video stream 0x0000..0x0007
        for (int i = 0; i < 8; i++) begin
            vid_req = 1'b1; vid_addr = AW'(i);
            vid_exp_d.push_back(pat(AW'(i)));
            mid();
            chk($sformatf("vs_gnt_%0d", i), 32'(vid_gnt), 1);
            chk($sformatf("vs_addr_%0d", i), 32'(mem_addr), 32'(i));
            if (i > 0) chk($sformatf("vs_valid_%0d", i), 32'(vid_valid), 1);
            cyc();
        end
        vid_req = 1'b0;
        mid();
        chk("vs_last_valid", 32'(vid_valid), 1);
        cyc();
        mid();
        chk("vs_valid_drops", 32'(vid_valid), 0);
        cyc();

        // Starvation guard: CPU raised at cycle 10 of a continuous stream
        starve(13'h0100, 10);

        // Simultaneous start: video first, CPU the following cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        vid_req = 1'b1; vid_addr = 13'h0003;
        cpu_exp_rd.push_back(1'b1); cpu_exp_d.push_back(8'hC3);
        vid_exp_d.push_back(pat(13'h0003));
        mid();
        chk("sim_c0_vid_gnt", 32'(vid_gnt), 1);
        chk("sim_c0_addr", 32'(mem_addr), 32'h0003);
        chk("sim_c0_wait_n", 32'(cpu_wait_n), 0);
        cyc();
        vid_req = 1'b0;
        mid();
        chk("sim_c1_vid_gnt", 32'(vid_gnt), 0);
        chk("sim_c1_mem_ce", 32'(mem_ce), 1);
        chk("sim_c1_addr", 32'(mem_addr), 32'h0010);
        cyc();
        mid();
        chk("sim_c2_ack", 32'(cpu_ack), 1);
        cyc();
        cpu_req = 1'b0;
        mid();
        cyc();
        // Streak must have restarted from zero: a full four video grants again
        starve(13'h0200, 0);

        // Reset asserted in the CPU grant cycle discards the access
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1800;
        mid();
        chk("rma_mem_ce", 32'(mem_ce), 0);
        chk("rma_wait_n", 32'(cpu_wait_n), 1);
        chk("rma_cpu_rdata", 32'(cpu_rdata), 0);
        cyc();
        reset = 1'b0; cpu_req = 1'b0;
        mid();
        chk("rma_c1_ack", 32'(cpu_ack), 0);
        chk("rma_c1_valid", 32'(vid_valid), 0);
        chk("rma_c1_wait_n", 32'(cpu_wait_n), 1);
        cyc();
        mid();
        chk("rma_c2_ack", 32'(cpu_ack), 0);
        cyc();
        // Idle FSM: a fresh request is granted in its first cycle
        cpu_op(1'b0, 13'h1800, 8'h00, 8'h5A, 2);

        repeat (3) cyc();
        chk("cpu_queue_drained", 32'(cpu_exp_d.size()), 0);
        chk("vid_queue_drained", 32'(vid_exp_d.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port 8 KB screen RAM (8K x 8, 1-cycle registered read) between two requesters on the spectrum clock domain:
  - the Z80 bus side (CPU);
  - the display fetch side (video).
- Video has priority because display fetch is deadline-bound. A streak counter guarantees the CPU a slot after at most MAX_VID_STREAK consecutive video grants.
- CPU stall is signalled through a Z80-style wait_n.

Parameters:
- ADDR_W, 13, RAM address width
- DATA_W, 8, RAM data width
- MAX_VID_STREAK, 4, consecutive video grants allowed while CPU pending (≥1)

Ports:
- clk  in  1  spectrum clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request (ram_cs & (rd|wr)), held level until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack, held until next CPU read ack
- cpu_ack  out  1  1-cycle pulse: CPU access complete
- cpu_wait_n  out  1  0 while CPU request pending and not yet acked
- vid_req  in  1  video fetch request, held with vid_addr until vid_gnt
- vid_addr  in  ADDR_W  video fetch address
- vid_gnt  out  1  combinational: video request accepted this cycle
- vid_rdata  out  DATA_W  fetched byte, valid with vid_valid
- vid_valid  out  1  1-cycle pulse, one cycle after vid_gnt
- mem_ce  out  1  RAM clock enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_ce with mem_we=0

Behaviour:
- Reset (sync, while reset=1):
  - outputs: cpu_ack=0, vid_valid=0, cpu_wait_n=1, vid_gnt=0, mem_ce=0, mem_we=0, cpu_rdata=0, vid_rdata=0;
  - state: FSM→C_IDLE, streak=0, owner pipe=OWN_NONE.
  - Reset mid-access discards it: no ack/valid is issued afterwards.
- CPU FSM:
  - C_IDLE: cpu_req=1 → C_PEND.
  - C_PEND: when CPU wins arbitration (cpu_grant) → C_BUSY.
  - C_BUSY: next cycle → C_DONE, cpu_ack pulses for one cycle in that cycle.
  - C_DONE: waits for cpu_req=0 → C_IDLE. A held request is never re-served, so Z80 multi-cycle rd_n/wr_n yields exactly one access.
  - Same-cycle entry: a request arriving in C_IDLE is arbitrated in that same cycle (cpu_pending = C_PEND, or C_IDLE & cpu_req).
- cpu_wait_n = ~(cpu_pending | state==C_BUSY). Minimum CPU latency: grant in cycle N, ack in N+1.
- Arbitration, evaluated each cycle:
  - cpu_grant = cpu_pending & (~vid_req | streak==MAX_VID_STREAK);
  - vid_gnt = vid_req & ~cpu_grant;
  - at most one grant per cycle.
- Streak counter:
  - +1 on vid_gnt while cpu_pending;
  - cleared on cpu_grant or when ~cpu_pending;
  - saturates at MAX_VID_STREAK.
- RAM drive on grant cycle: mem_ce=1, mem_addr=winner address.
  - mem_we=cpu_we only for a CPU grant (video never writes); mem_wdata=cpu_wdata.
- Owner pipe: a registered owner (OWN_NONE/CPU/VID) plus a read flag.
  - Next cycle, OWN_VID: vid_rdata←mem_rdata, vid_valid=1.
  - Next cycle, OWN_CPU read: cpu_rdata←mem_rdata.
  - OWN_CPU write: cpu_ack only, cpu_rdata unchanged.
- Simultaneous events:
  - vid_req and new cpu_req in the same cycle, streak<MAX → video wins.
  - cpu_req dropped while in C_PEND (illegal) → return to C_IDLE, no access.
- Back-to-back: video may be granted every cycle; vid_valid then pulses every cycle, one cycle delayed.

Decomposition:
- Shared package spectrum_pkg:
  - ADDR_W/DATA_W defaults;
  - owner enum OWN_NONE/OWN_CPU/OWN_VID;
  - CPU FSM enum C_IDLE/C_PEND/C_BUSY/C_DONE.
- No sub-module; a single flat module is sufficient.

Test Plan:
- CPU read alone: RAM[0x1800]=0x5A, cpu_req/we=0/addr=0x1800 at cycle 0 → mem_ce at 0, cpu_ack+cpu_rdata=0x5A at 1, cpu_wait_n low only in cycles 0–1.
- CPU write, req held 4 cycles: addr=0x0010, wdata=0xC3 → exactly one mem_we pulse, one cpu_ack; subsequent read returns 0xC3.
- Video stream: vid_req held continuously, addr incrementing 0x0000..0x0007 → vid_gnt every cycle, 8 vid_valid pulses each one cycle later with correct bytes.
- Starvation guard: vid_req continuous, cpu_req raised at cycle 10, MAX_VID_STREAK=4 → video granted cycles 10–13, CPU at 14, ack at 15, video resumes at 15.
- Simultaneous start: cpu_req and vid_req both rise at the same cycle → vid_gnt first, CPU granted the next cycle, streak back to 0 afterwards.
- Reset mid-access: reset asserted in the CPU grant cycle → no cpu_ack, cpu_wait_n=1, vid_valid=0, FSM in C_IDLE after reset release.
